// File: rtl/ahbl_pkg.sv
// ahbl_pkg: shared AHB-Lite encodings and helpers for the two-master arbiter
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_t;

    // Effective transfer type of a master: a buffered request always replays as
    // NONSEQ, and BUSY collapses to IDLE.
    function automatic logic [1:0] norm_trans(input logic pend, input logic [1:0] trans);
        return pend ? HTRANS_NONSEQ : (trans[1] ? trans : HTRANS_IDLE);
    endfunction

endpackage

// File: rtl/ahbl_addr_buf.sv
// ahbl_addr_buf: holds the address phase of a master that lost arbitration
module ahbl_addr_buf
    import ahbl_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          capture,
    input  logic          issue,
    input  logic [AW-1:0] addr,
    input  logic [2:0]    size,
    input  logic          write,
    output logic          pend,
    output logic [AW-1:0] held_addr,
    output logic [2:0]    held_size,
    output logic          held_write
);

    // Capture a losing request; drop the pending flag once the bus accepts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= 1'b0;
            held_addr  <= '0;
            held_size  <= '0;
            held_write <= 1'b0;
        end else if (capture) begin
            pend       <= 1'b1;
            held_addr  <= addr;
            held_size  <= size;
            held_write <= write;
        end else if (issue) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/ahbl_master_arbiter.sv
// ahbl_master_arbiter: shares one AHB-Lite bus between the CPU (M0) and a second master (M1)
module ahbl_master_arbiter
    import ahbl_pkg::*;
#(
    parameter bit RR_EN = 1'b1,
    parameter int AW    = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic [2:0]    M0_HSIZE,
    input  logic          M0_HWRITE,
    input  logic [31:0]   M0_HWDATA,
    output logic          M0_HREADY,
    output logic [31:0]   M0_HRDATA,
    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic [2:0]    M1_HSIZE,
    input  logic          M1_HWRITE,
    input  logic [31:0]   M1_HWDATA,
    output logic          M1_HREADY,
    output logic [31:0]   M1_HRDATA,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic [2:0]    HSIZE,
    output logic          HWRITE,
    output logic [31:0]   HWDATA,
    input  logic          HREADY,
    input  logic [31:0]   HRDATA
);

    owner_t        dph_owner, dph_next;
    logic          pend0, pend1, cap0, cap1, iss0, iss1;
    logic [AW-1:0] baddr0, baddr1, addr0, addr1;
    logic [2:0]    bsize0, bsize1, size0, size1;
    logic          bwrite0, bwrite1, write0, write1;
    logic [1:0]    trans0, trans1;
    logic          last_grant, gnt_hold, hold_valid, seq_hold, arb, grant;

    ahbl_addr_buf #(.AW(AW)) u_buf0 (
        .clk(HCLK), .rst_n(HRESETn), .capture(cap0), .issue(iss0),
        .addr(M0_HADDR), .size(M0_HSIZE), .write(M0_HWRITE),
        .pend(pend0), .held_addr(baddr0), .held_size(bsize0), .held_write(bwrite0)
    );

    ahbl_addr_buf #(.AW(AW)) u_buf1 (
        .clk(HCLK), .rst_n(HRESETn), .capture(cap1), .issue(iss1),
        .addr(M1_HADDR), .size(M1_HSIZE), .write(M1_HWRITE),
        .pend(pend1), .held_addr(baddr1), .held_size(bsize1), .held_write(bwrite1)
    );

    // Effective address phase per master: buffered copy wins over live signals
    assign trans0 = norm_trans(pend0, M0_HTRANS);
    assign trans1 = norm_trans(pend1, M1_HTRANS);
    assign addr0  = pend0 ? baddr0 : M0_HADDR;
    assign addr1  = pend1 ? baddr1 : M1_HADDR;
    assign size0  = pend0 ? bsize0 : M0_HSIZE;
    assign size1  = pend1 ? bsize1 : M1_HSIZE;
    assign write0 = pend0 ? bwrite0 : M0_HWRITE;
    assign write1 = pend1 ? bwrite1 : M1_HWRITE;

    // grant: 0 selects M0, 1 selects M1; an idle bus parks on M0.
    // A burst in progress keeps the bus; during wait states the grant is frozen.
    assign seq_hold = (last_grant ? trans1 : trans0) == HTRANS_SEQ;
    assign arb      = seq_hold ? last_grant : trans1[1] & (!trans0[1] | (RR_EN & !last_grant));
    assign grant    = hold_valid ? gnt_hold : arb;

    assign HADDR  = grant ? addr1 : addr0;
    assign HTRANS = grant ? trans1 : trans0;
    assign HSIZE  = grant ? size1 : size0;
    assign HWRITE = grant ? write1 : write0;
    assign HWDATA = (dph_owner == OWN_M0) ? M0_HWDATA : (dph_owner == OWN_M1) ? M1_HWDATA : '0;

    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;
    assign M0_HREADY = (dph_owner == OWN_M0) ? HREADY : !(pend0 | (!grant & !HREADY));
    assign M1_HREADY = (dph_owner == OWN_M1) ? HREADY : !(pend1 | (grant & !HREADY));

    // A master whose live request is accepted from its own view but not granted gets buffered
    assign cap0 = !pend0 & M0_HTRANS[1] & M0_HREADY & grant;
    assign cap1 = !pend1 & M1_HTRANS[1] & M1_HREADY & !grant;
    assign iss0 = HREADY & pend0 & !grant;
    assign iss1 = HREADY & pend1 & grant;

    // Data-phase owner register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) dph_owner <= OWN_NONE;
        else          dph_owner <= dph_next;
    end

    // Next data-phase owner: advances only when the bus accepts the address phase
    always_comb begin
        dph_next = dph_owner;
        if (HREADY) dph_next = !HTRANS[1] ? OWN_NONE : grant ? OWN_M1 : OWN_M0;
    end

    // Round-robin history and grant freeze across bus wait states
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_grant <= 1'b1;
            gnt_hold   <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            hold_valid <= !HREADY;
            gnt_hold   <= grant;
            if (HREADY && HTRANS[1]) last_grant <= grant;
        end
    end

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// tb_ahbl_master_arbiter: directed self-checking bench for the two-master arbiter
module tb_ahbl_master_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
    logic [1:0]  m0_htrans, m1_htrans;
    logic [2:0]  m0_hsize, m1_hsize;
    logic        m0_hwrite, m1_hwrite;
    logic        hready;
    logic [31:0] hrdata;

    logic        m0_hready, m1_hready;
    logic [31:0] m0_hrdata, m1_hrdata, haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;

    logic        fp_m0_hready, fp_m1_hready;
    logic [31:0] fp_m0_hrdata, fp_m1_hrdata, fp_haddr, fp_hwdata;
    logic [1:0]  fp_htrans;
    logic [2:0]  fp_hsize;
    logic        fp_hwrite;

    int n_checks = 0;
    int n_errors = 0;

    always #5 HCLK = ~HCLK;

    ahbl_master_arbiter #(.RR_EN(1'b1), .AW(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HSIZE(m0_hsize), .M0_HWRITE(m0_hwrite),
        .M0_HWDATA(m0_hwdata), .M0_HREADY(m0_hready), .M0_HRDATA(m0_hrdata),
        .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HSIZE(m1_hsize), .M1_HWRITE(m1_hwrite),
        .M1_HWDATA(m1_hwdata), .M1_HREADY(m1_hready), .M1_HRDATA(m1_hrdata),
        .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata),
        .HREADY(hready), .HRDATA(hrdata)
    );

    ahbl_master_arbiter #(.RR_EN(1'b0), .AW(32)) dut_fp (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HSIZE(m0_hsize), .M0_HWRITE(m0_hwrite),
        .M0_HWDATA(m0_hwdata), .M0_HREADY(fp_m0_hready), .M0_HRDATA(fp_m0_hrdata),
        .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HSIZE(m1_hsize), .M1_HWRITE(m1_hwrite),
        .M1_HWDATA(m1_hwdata), .M1_HREADY(fp_m1_hready), .M1_HRDATA(fp_m1_hrdata),
        .HADDR(fp_haddr), .HTRANS(fp_htrans), .HSIZE(fp_hsize), .HWRITE(fp_hwrite), .HWDATA(fp_hwdata),
        .HREADY(hready), .HRDATA(hrdata)
    );

    // Tiny slave memory behind the RR instance, indexed by {addr[30:29], addr[5:2]}
    logic [31:0] mem [64];
    logic        dp_valid, dp_write;
    logic [31:0] dp_addr;

    function automatic logic [5:0] idx(input logic [31:0] a);
        return {a[30:29], a[5:2]};
    endfunction

    assign hrdata = (dp_valid && !dp_write) ? mem[idx(dp_addr)] : 32'h0;

    // Slave data phase: latch accepted address, commit writes when the data phase ends
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= 32'h0;
        end else if (hready) begin
            if (dp_valid && dp_write) mem[idx(dp_addr)] <= hwdata;
            dp_valid <= htrans[1];
            dp_addr  <= haddr;
            dp_write <= hwrite;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_all();
        m0_htrans = 2'b00; m0_haddr = 32'h0; m0_hsize = 3'd2; m0_hwrite = 1'b0; m0_hwdata = 32'h0;
        m1_htrans = 2'b00; m1_haddr = 32'h0; m1_hsize = 3'd2; m1_hwrite = 1'b0; m1_hwdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_all();
        hready  = 1'b1;
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    task automatic m0_req(input logic [1:0] t, input logic [31:0] a, input logic w);
        m0_htrans = t; m0_haddr = a; m0_hwrite = w;
    endtask

    task automatic m1_req(input logic [1:0] t, input logic [31:0] a, input logic w);
        m1_htrans = t; m1_haddr = a; m1_hwrite = w;
    endtask

    initial begin
        mem[4]  = 32'h1234_5678;
        mem[32] = 32'hCAFE_0001;
        do_reset();
        #2;
        check("rst_htrans", {30'h0, htrans}, 32'h0);
        check("rst_m0_hready", {31'h0, m0_hready}, 32'h1);
        check("rst_m1_hready", {31'h0, m1_hready}, 32'h1);
        check("rst_hwdata", hwdata, 32'h0);

        // Uncontended M0 read: zero added latency
        tick();
        m0_req(2'b10, 32'h0000_0010, 1'b0);
        #2;
        check("t1_haddr", haddr, 32'h0000_0010);
        check("t1_htrans", {30'h0, htrans}, 32'h2);
        check("t1_m0_hready", {31'h0, m0_hready}, 32'h1);
        tick();
        idle_all();
        #2;
        check("t1_m0_hrdata", m0_hrdata, 32'h1234_5678);
        check("t1_m0_hready_dp", {31'h0, m0_hready}, 32'h1);

        // Back-to-back conflicts: RR winners M0, M1, M0, M1; fixed priority keeps M0
        do_reset();
        m0_req(2'b10, 32'h2000_0000, 1'b0);
        m1_req(2'b10, 32'h4000_0000, 1'b0);
        #2;
        check("t2_rr_haddr_a", haddr, 32'h2000_0000);
        check("t2_fp_haddr_a", fp_haddr, 32'h2000_0000);
        check("t2_m1_hready_a", {31'h0, m1_hready}, 32'h1);
        tick();
        m0_req(2'b10, 32'h2000_0004, 1'b0);
        m1_req(2'b10, 32'h4000_0004, 1'b0);
        #2;
        check("t2_rr_haddr_b", haddr, 32'h4000_0000);
        check("t2_m1_hready_b", {31'h0, m1_hready}, 32'h0);
        check("t2_m0_hready_b", {31'h0, m0_hready}, 32'h1);
        check("t2_fp_haddr_b", fp_haddr, 32'h2000_0004);
        tick();
        m0_req(2'b00, 32'h0, 1'b0);
        #2;
        check("t3_rr_haddr_c", haddr, 32'h2000_0004);
        check("t3_m0_hready_c", {31'h0, m0_hready}, 32'h0);
        check("t3_m1_hrdata_c", m1_hrdata, 32'hCAFE_0001);
        check("t3_fp_haddr_c", fp_haddr, 32'h4000_0000);
        tick();
        m1_req(2'b00, 32'h0, 1'b0);
        #2;
        check("t3_rr_haddr_d", haddr, 32'h4000_0004);
        check("t3_rr_htrans_d", {30'h0, htrans}, 32'h2);
        tick();
        #2;
        check("t3_htrans_idle", {30'h0, htrans}, 32'h0);

        // M1 write with two slave wait states, then read back
        do_reset();
        m1_req(2'b10, 32'h2000_0004, 1'b1);
        #2;
        check("t4_haddr", haddr, 32'h2000_0004);
        check("t4_hwrite", {31'h0, hwrite}, 32'h1);
        tick();
        m1_req(2'b00, 32'h0, 1'b0);
        m1_hwdata = 32'hDEAD_BEEF;
        hready = 1'b0;
        #2;
        check("t4_m1_hready_w1", {31'h0, m1_hready}, 32'h0);
        check("t4_hwdata_w1", hwdata, 32'hDEAD_BEEF);
        tick();
        #2;
        check("t4_m1_hready_w2", {31'h0, m1_hready}, 32'h0);
        check("t4_hwdata_w2", hwdata, 32'hDEAD_BEEF);
        tick();
        hready = 1'b1;
        #2;
        check("t4_m1_hready_done", {31'h0, m1_hready}, 32'h1);
        tick();
        m1_hwdata = 32'h0;
        m1_req(2'b10, 32'h2000_0004, 1'b0);
        tick();
        m1_req(2'b00, 32'h0, 1'b0);
        #2;
        check("t4_readback", m1_hrdata, 32'hDEAD_BEEF);

        // M0 four-beat SEQ burst keeps the bus while M1 waits
        do_reset();
        m0_req(2'b10, 32'h0000_0100, 1'b0);
        m1_req(2'b10, 32'h4000_0020, 1'b0);
        #2;
        check("t5_beat0", haddr, 32'h0000_0100);
        tick();
        m1_req(2'b00, 32'h0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            m0_req(2'b11, 32'h0000_0100 + 32'(4 * i), 1'b0);
            #2;
            check($sformatf("t5_beat%0d", i), haddr, 32'h0000_0100 + 32'(4 * i));
            check($sformatf("t5_m1_wait%0d", i), {31'h0, m1_hready}, 32'h0);
            tick();
        end
        m0_req(2'b00, 32'h0, 1'b0);
        #2;
        check("t5_m1_issued", haddr, 32'h4000_0020);
        check("t5_m1_htrans", {30'h0, htrans}, 32'h2);
        tick();
        #2;
        check("t5_m1_hready_dp", {31'h0, m1_hready}, 32'h1);

        // Reset while M1 holds a buffered request drops it
        do_reset();
        m0_req(2'b10, 32'h2000_0000, 1'b0);
        m1_req(2'b10, 32'h4000_0000, 1'b0);
        tick();
        idle_all();
        HRESETn = 1'b0;
        #2;
        check("t6_htrans_in_rst", {30'h0, htrans}, 32'h0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        #2;
        check("t6_htrans", {30'h0, htrans}, 32'h0);
        check("t6_m0_hready", {31'h0, m0_hready}, 32'h1);
        check("t6_m1_hready", {31'h0, m1_hready}, 32'h1);
        tick();
        #2;
        check("t6_no_replay", {30'h0, htrans}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
